// File: rtl/fmap_streamer4_if.sv
// Buffer-read port and pixel-lane bundle for fmap_streamer4.
// pos_row/pos_col are present only when FMAP_STREAMER_POS_EN is defined.
interface fmap_streamer4_if #(
  parameter int BIT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MAP_SIZE   = 14
);
  localparam int PW = $clog2(MAP_SIZE);

  logic                        start;
  logic                        hold;
  logic                        rd_en;
  logic [ADDR_WIDTH-1:0]       rd_addr;
  logic signed [BIT_WIDTH-1:0] rd_data0, rd_data1, rd_data2, rd_data3;
  logic                        conv_clr;
  logic                        conv_en;
  logic signed [BIT_WIDTH-1:0] next0, next1, next2, next3;
  logic                        win_valid;
  logic                        busy;
  logic                        done;
`ifdef FMAP_STREAMER_POS_EN
  logic [PW-1:0]               pos_row;
  logic [PW-1:0]               pos_col;
`endif

  // master is the streamer; slave is the buffer/core/controller side
  modport master (
    input  start, hold, rd_data0, rd_data1, rd_data2, rd_data3,
    output rd_en, rd_addr, conv_clr, conv_en, next0, next1, next2, next3,
           win_valid, busy, done
`ifdef FMAP_STREAMER_POS_EN
    , output pos_row, pos_col
`endif
  );

  modport slave (
    output start, hold, rd_data0, rd_data1, rd_data2, rd_data3,
    input  rd_en, rd_addr, conv_clr, conv_en, next0, next1, next2, next3,
           win_valid, busy, done
`ifdef FMAP_STREAMER_POS_EN
    , input pos_row, pos_col
`endif
  );
endinterface

// File: rtl/fmap_streamer4.sv
// Streams four MAP_SIZE x MAP_SIZE feature maps in raster order as four pixel lanes.
// Optional FMAP_STREAMER_POS_EN adds pos_row/pos_col outputs for the presented pixel.
module fmap_streamer4 #(
  parameter int BIT_WIDTH  = 8,
  parameter int MAP_SIZE   = 14,
  parameter int KERNEL     = 5,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  fmap_streamer4_if.master    bus
);
  localparam int CW = $clog2(MAP_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MAP_SIZE*MAP_SIZE-1);
  localparam logic [CW-1:0]         LAST_COL = CW'(MAP_SIZE-1);
  localparam logic [CW-1:0]         WIN_MIN  = CW'(KERNEL-1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [CW-1:0]         row_reg, col_reg;
  logic                  drain_reg;
  logic                  conv_clr_reg, busy_reg, done_reg;
  logic                  rd_fire;

  // hold gates the strobe in the same cycle so no read is ever issued under backpressure
  assign rd_fire     = (state_reg == FETCH) && !bus.hold;
  assign bus.rd_en   = rd_fire;
  assign bus.rd_addr = addr_reg;
  assign bus.conv_clr = conv_clr_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      row_reg      <= '0;
      col_reg      <= '0;
      drain_reg    <= 1'b0;
      conv_clr_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      conv_clr_reg <= 1'b0;
      done_reg     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg    <= FETCH;
            addr_reg     <= '0;
            row_reg      <= '0;
            col_reg      <= '0;
            conv_clr_reg <= 1'b1;
            busy_reg     <= 1'b1;
          end
        end
        FETCH: begin
          if (!bus.hold) begin
            addr_reg <= addr_reg + ADDR_WIDTH'(1);
            if (col_reg == LAST_COL) begin
              col_reg <= '0;
              row_reg <= row_reg + CW'(1);
            end else begin
              col_reg <= col_reg + CW'(1);
            end
            if (addr_reg == LAST_IDX) begin
              state_reg <= DRAIN;
              drain_reg <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // two cycles: buffer latency, then the lane register
          drain_reg <= 1'b1;
          if (drain_reg) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Stage 1 travels alongside the returning buffer data
  logic          v1_reg;
  logic [CW-1:0] row1_reg, col1_reg;
  logic          conv_en_reg, win_valid_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_reg        <= 1'b0;
      row1_reg      <= '0;
      col1_reg      <= '0;
      conv_en_reg   <= 1'b0;
      win_valid_reg <= 1'b0;
    end else begin
      v1_reg        <= rd_fire;
      row1_reg      <= row_reg;
      col1_reg      <= col_reg;
      conv_en_reg   <= v1_reg;
      win_valid_reg <= v1_reg && (row1_reg >= WIN_MIN) && (col1_reg >= WIN_MIN);
    end
  end

  assign bus.conv_en   = conv_en_reg;
  assign bus.win_valid = win_valid_reg;

  logic signed [BIT_WIDTH-1:0] lane_in [4];
  assign lane_in[0] = bus.rd_data0;
  assign lane_in[1] = bus.rd_data1;
  assign lane_in[2] = bus.rd_data2;
  assign lane_in[3] = bus.rd_data3;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic signed [BIT_WIDTH-1:0] lane_reg;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)        lane_reg <= '0;
      else if (v1_reg) lane_reg <= lane_in[gi];
    end
  end

  assign bus.next0 = g_lane[0].lane_reg;
  assign bus.next1 = g_lane[1].lane_reg;
  assign bus.next2 = g_lane[2].lane_reg;
  assign bus.next3 = g_lane[3].lane_reg;

`ifdef FMAP_STREAMER_POS_EN
  logic [CW-1:0] pos_row_reg, pos_col_reg;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_row_reg <= '0;
      pos_col_reg <= '0;
    end else if (v1_reg) begin
      pos_row_reg <= row1_reg;
      pos_col_reg <= col1_reg;
    end
  end
  assign bus.pos_row = pos_row_reg;
  assign bus.pos_col = pos_col_reg;
`endif
endmodule

// File: tb/tb_fmap_streamer4.sv
// Directed bench for fmap_streamer4: table of frame scenarios plus reset/abort sequences.
// Checks pos_row/pos_col too when FMAP_STREAMER_POS_EN is defined.
module tb_fmap_streamer4;
  localparam int BW = 8, MS = 14, KN = 5, AW = 8;
  localparam int NPIX = MS * MS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fmap_streamer4_if #(.BIT_WIDTH(BW), .ADDR_WIDTH(AW), .MAP_SIZE(MS)) bus ();

  fmap_streamer4 #(.BIT_WIDTH(BW), .MAP_SIZE(MS), .KERNEL(KN), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // single-cycle-latency buffer: map N pixel = (addr + N) mod 128
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_data0 <= BW'((int'(bus.rd_addr) + 0) % 128);
      bus.rd_data1 <= BW'((int'(bus.rd_addr) + 1) % 128);
      bus.rd_data2 <= BW'((int'(bus.rd_addr) + 2) % 128);
      bus.rd_data3 <= BW'((int'(bus.rd_addr) + 3) % 128);
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc_g  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc_g, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rd_en"},     bus.rd_en, 0);
    chk({tag, "_rd_addr"},   bus.rd_addr, 0);
    chk({tag, "_conv_clr"},  bus.conv_clr, 0);
    chk({tag, "_conv_en"},   bus.conv_en, 0);
    chk({tag, "_win_valid"}, bus.win_valid, 0);
    chk({tag, "_busy"},      bus.busy, 0);
    chk({tag, "_done"},      bus.done, 0);
    chk({tag, "_next0"},     32'(8'(bus.next0)), 0);
    chk({tag, "_next1"},     32'(8'(bus.next1)), 0);
    chk({tag, "_next2"},     32'(8'(bus.next2)), 0);
    chk({tag, "_next3"},     32'(8'(bus.next3)), 0);
`ifdef FMAP_STREAMER_POS_EN
    chk({tag, "_pos_row"},   32'(bus.pos_row), 0);
    chk({tag, "_pos_col"},   32'(bus.pos_col), 0);
`endif
  endtask

  typedef struct {
    int hold_at;
    int hold_len;
    bit stray;
    int extra;
    int exp_conv;
    int exp_win;
    int exp_done;
    int exp_gaps;
    int exp_first;
  } vec_t;

  // Cycle 0 carries start; cycle c is the c-th cycle after the accepting edge.
  task automatic run_frame(input int fid, input vec_t v);
    bit exp_cv [0:511];
    int exp_ix [0:511];
    int rd_cnt = 0, held = 0, dcyc, er, ec;
    int n_conv = 0, n_win = 0, n_done = 0, done_at = -1, gaps = 0, first_win = -1;
    bit exp_rden;
    for (int i = 0; i < 512; i++) begin exp_cv[i] = 1'b0; exp_ix[i] = 0; end
    dcyc = 199 + v.hold_len;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.hold  = 1'b0;
    for (int c = 1; c <= dcyc + v.extra; c++) begin
      @(posedge clk); #1;
      cyc_g     = c;
      bus.start = v.stray && (c == 50 || c == dcyc);
      bus.hold  = (v.hold_len > 0) && (rd_cnt == v.hold_at) && (held < v.hold_len);
      if (bus.hold) held++;
      exp_rden = !bus.hold && (rd_cnt < NPIX);
      @(negedge clk);
      chk("rd_en", bus.rd_en, exp_rden);
      if (exp_rden) begin
        chk("rd_addr", bus.rd_addr, rd_cnt);
        exp_cv[c+2] = 1'b1;
        exp_ix[c+2] = rd_cnt;
        rd_cnt++;
      end
      chk("conv_clr", bus.conv_clr, c == 1);
      chk("busy", bus.busy, c < dcyc);
      chk("done", bus.done, c == dcyc);
      chk("conv_en", bus.conv_en, exp_cv[c]);
      if (exp_cv[c]) begin
        er = exp_ix[c] / MS;
        ec = exp_ix[c] % MS;
        chk("next0", 32'(8'(bus.next0)), (exp_ix[c] + 0) % 128);
        chk("next1", 32'(8'(bus.next1)), (exp_ix[c] + 1) % 128);
        chk("next2", 32'(8'(bus.next2)), (exp_ix[c] + 2) % 128);
        chk("next3", 32'(8'(bus.next3)), (exp_ix[c] + 3) % 128);
        chk("win_valid", bus.win_valid, (er >= KN-1) && (ec >= KN-1));
`ifdef FMAP_STREAMER_POS_EN
        chk("pos_row", 32'(bus.pos_row), er);
        chk("pos_col", 32'(bus.pos_col), ec);
`endif
      end else begin
        chk("win_valid_idle", bus.win_valid, 0);
      end
      if (bus.conv_en === 1'b1) n_conv++;
      if (bus.win_valid === 1'b1) begin
        n_win++;
        if (first_win < 0) first_win = exp_cv[c] ? exp_ix[c] : -2;
      end
      if (bus.done === 1'b1) begin n_done++; done_at = c; end
      if (c >= 3 && c <= 198 + v.hold_len && bus.conv_en !== 1'b1) gaps++;
    end
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    chk("frame_conv_count", n_conv, v.exp_conv);
    chk("frame_win_count", n_win, v.exp_win);
    chk("frame_done_count", n_done, 1);
    chk("frame_done_cycle", done_at, v.exp_done);
    chk("frame_gaps", gaps, v.exp_gaps);
    chk("frame_first_win_idx", first_win, v.exp_first);
    $display("frame %0d hold_len=%0d stray=%0d conv=%0d win=%0d done_at=%0d gaps=%0d",
             fid, v.hold_len, v.stray, n_conv, n_win, done_at, gaps);
  endtask

  initial begin
    vec_t vecs [3];
    bit found;
    vecs[0] = '{hold_at: -1, hold_len: 0, stray: 1'b0, extra: 0,
                exp_conv: 196, exp_win: 100, exp_done: 199, exp_gaps: 0, exp_first: 60};
    vecs[1] = '{hold_at: 20, hold_len: 3, stray: 1'b0, extra: 0,
                exp_conv: 196, exp_win: 100, exp_done: 202, exp_gaps: 3, exp_first: 60};
    vecs[2] = '{hold_at: -1, hold_len: 0, stray: 1'b1, extra: 3,
                exp_conv: 196, exp_win: 100, exp_done: 199, exp_gaps: 0, exp_first: 60};

    bus.start = 1'b0;
    bus.hold  = 1'b0;
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk_outputs_zero("post_reset_idle");

    // frames run back to back: each start lands in the cycle right after done
    for (int i = 0; i < 3; i++) run_frame(i, vecs[i]);

    // abort mid-frame with an asynchronous reset
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (bus.rd_en === 1'b1 && bus.rd_addr === AW'(100)) found = 1'b1;
    end
    chk("abort_reach_idx100", found, 1);
    #1 rst = 1'b0;
    #1;
    chk_outputs_zero("async_abort");
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_no_done", bus.done, 0);
      chk("abort_no_busy", bus.busy, 0);
      chk("abort_no_rd_en", bus.rd_en, 0);
    end
    run_frame(3, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fmap_streamer4.md
# fmap_streamer4

Frame reader for the second convolution layer. It reads four MAP_SIZE x MAP_SIZE feature maps in lock-step from a single-cycle-latency buffer port and streams them in raster order as four pixel lanes, one pixel per lane per cycle. The lanes drive a 4-channel 5x5 convolution core through the core's enable and clear inputs. It also flags every pixel whose 5x5 window lies fully inside the map, so the downstream collector can keep only valid convolution outputs.

## Interface
- BIT_WIDTH, 8, pixel width (signed)
- MAP_SIZE, 14, feature-map side length in pixels
- KERNEL, 5, convolution window side; sets the valid-window threshold
- ADDR_WIDTH, 8, buffer address width; must satisfy 2^ADDR_WIDTH >= MAP_SIZE*MAP_SIZE

- clk  in  1  clock; all logic on the rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to stream one frame; honoured only in IDLE
- hold  in  1  backpressure; while high, no new buffer reads are issued
- rd_en  out  1  buffer read strobe
- rd_addr  out  ADDR_WIDTH  pixel index r*MAP_SIZE+c
- rd_data0..rd_data3  in  BIT_WIDTH each  map 0..3 pixels, valid the cycle after rd_en
- conv_clr  out  1  one-cycle clear for the convolution core's line buffers
- conv_en  out  1  pixel lanes valid; drives the core's enable
- next0..next3  out  BIT_WIDTH each  registered pixel lanes
- win_valid  out  1  qualifies conv_en; the pixel on the lanes completes a full KERNEL x KERNEL window
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last pixel is presented

## Operation
- States:
  - IDLE: default state.
  - FETCH: issue reads.
  - DRAIN: wait for in-flight data.
  - DONE: pulse done.
- IDLE -> FETCH: start=1. Clears the address, row and column counters and asserts conv_clr for exactly one cycle, which is the first FETCH cycle.
- FETCH, hold=0:
  - rd_en=1 and rd_addr=current index.
  - The index increments; col wraps MAP_SIZE-1 -> 0 and increments row.
- FETCH, hold=1: rd_en=0 and the counters freeze.
- FETCH -> DRAIN: the read of index MAP_SIZE*MAP_SIZE-1 is issued.
- DRAIN lasts 2 cycles (buffer latency plus output register), then goes to DONE.
- DONE lasts 1 cycle with done=1, then goes to IDLE.
- Data path: rd_en, row and col are delayed 1 cycle alongside the returning rd_data. next*, conv_en and win_valid are registered from that stage. hold never drops a read that is already in flight.
- win_valid = conv_en AND row >= KERNEL-1 AND col >= KERNEL-1, using the row and col of the presented pixel.
- busy=1 in FETCH and DRAIN, 0 in IDLE and DONE.
- start in any state other than IDLE is ignored. A start in the DONE cycle is ignored.
- Asserting rst mid-frame aborts the frame and returns to IDLE. No done pulse is produced.

## Timing
- Reset values: rd_en, conv_clr, conv_en, win_valid, busy and done are 0. rd_addr and next0..3 are 0. The state is IDLE.
- start high at edge k: the cycle after edge k has conv_clr=1, rd_en=1, rd_addr=0 and busy=1.
- Pixel read at cycle t appears on next*, with conv_en=1, in cycle t+2. Read latency to lanes is 2 cycles.
- No hold, MAP_SIZE=14: reads occupy cycles k+1 .. k+196 and conv_en occupies k+3 .. k+198. done=1 and busy=0 in k+199. Back-to-back start is accepted at edge k+200.
- Each hold cycle in FETCH delays every later event by exactly 1 cycle and inserts one conv_en=0 gap.

## Configuration
- Macro FMAP_STREAMER_POS_EN.
  - Defined: adds outputs pos_row and pos_col, each $clog2(MAP_SIZE) bits. They carry the row and column of the pixel on next*, update with conv_en and reset to 0. They hold their value when conv_en=0.
  - Undefined: these ports and their registers do not exist. All other behaviour is identical.

## Test plan
- Reset then a single start with MAP_SIZE=14, rd_dataN = (addr + N) mod 128 -> conv_en high for 196 consecutive cycles starting 2 cycles after the first rd_en. next2 in pixel 0 equals 2. done pulses once, 1 cycle after the last conv_en.
- Same frame, count win_valid -> exactly 100 cycles (10x10). The first is at pixel (4,4), index 60. None appear where col<4.
- hold=1 for 3 cycles starting at read index 20 -> exactly 3 conv_en gaps. Lane sequence unchanged. done delayed by exactly 3 cycles.
- start pulsed during FETCH and during DONE -> ignored. Exactly one frame is streamed and one done pulse is produced.
- rst low at read index 100 -> all outputs 0 asynchronously with no done pulse. A following start streams a full frame from index 0 with conv_clr pulsed.
- With FMAP_STREAMER_POS_EN defined -> pos_row/pos_col equal (13,13) on the last conv_en and (4,4) on the first win_valid.
